// File: rtl/key_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// key_ctrl_pkg
// Shared types, command indices and BCD / seven-segment helpers for key_ctrl.
// Revision: 1.0
// ============================================================================
package key_ctrl_pkg;

   // Debounce FSM states
   typedef enum logic [1:0] {
      DB_RELEASED    = 2'd0,
      DB_CHK_PRESS   = 2'd1,
      DB_PRESSED     = 2'd2,
      DB_CHK_RELEASE = 2'd3
   } deb_state_t;

   // Command bit positions in cmd_pulse (also the key index that issues them)
   localparam int CMD_INC = 0;
   localparam int CMD_DEC = 1;
   localparam int CMD_CLR = 2;

   // Active-low seven-segment code, bit0 = segment a .. bit6 = segment g
   function automatic logic [6:0] seg7(input logic [3:0] d);
      logic [6:0] s;
      case (d)
         4'd0:    s = 7'h40;
         4'd1:    s = 7'h79;
         4'd2:    s = 7'h24;
         4'd3:    s = 7'h30;
         4'd4:    s = 7'h19;
         4'd5:    s = 7'h12;
         4'd6:    s = 7'h02;
         4'd7:    s = 7'h78;
         4'd8:    s = 7'h00;
         4'd9:    s = 7'h10;
         default: s = 7'h7F;
      endcase
      return s;
   endfunction

   // One BCD digit plus carry-in; returns {carry_out, digit}
   function automatic logic [4:0] bcd_inc_digit(input logic [3:0] d, input logic cin);
      logic [4:0] r;
      if (!cin)          r = {1'b0, d};
      else if (d >= 4'd9) r = {1'b1, 4'd0};
      else               r = {1'b0, d + 4'd1};
      return r;
   endfunction

   // One BCD digit minus borrow-in; returns {borrow_out, digit}
   function automatic logic [4:0] bcd_dec_digit(input logic [3:0] d, input logic bin);
      logic [4:0] r;
      if (!bin)          r = {1'b0, d};
      else if (d == 4'd0) r = {1'b1, 4'd9};
      else               r = {1'b0, d - 4'd1};
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/key_debounce.sv
`default_nettype none
// ============================================================================
// key_debounce
// Two-flop synchronizer followed by a four-state debounce FSM. o_press is a
// one-cycle strobe, asserted combinationally on the cycle the press qualifies.
// Revision: 1.0
// ============================================================================
module key_debounce
   import key_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 4,
   parameter logic        KEY_ACT    = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_key,
   output logic o_press
);

   localparam logic [15:0] c_CNT_LAST = 16'(DEB_CYCLES - 1);

   logic        r_sync1;
   logic        r_sync2;
   deb_state_t  r_state;
   deb_state_t  w_state_nxt;
   logic [15:0] r_cnt;
   logic [15:0] w_cnt_nxt;
   logic        w_lvl;

   assign w_lvl = (r_sync2 == KEY_ACT);

   // Synchronizer, state and stability counter registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sync1 <= 1'b0;
         r_sync2 <= 1'b0;
         r_state <= DB_RELEASED;
         r_cnt   <= '0;
      end else begin
         r_sync1 <= i_key;
         r_sync2 <= r_sync1;
         r_state <= w_state_nxt;
         r_cnt   <= w_cnt_nxt;
      end
   end

   // Next-state, counter and press-event decode
   always_comb begin
      w_state_nxt = r_state;
      w_cnt_nxt   = r_cnt;
      o_press     = 1'b0;
      case (r_state)
         DB_RELEASED: begin
            if (w_lvl) begin
               w_state_nxt = DB_CHK_PRESS;
               w_cnt_nxt   = '0;
            end
         end
         DB_CHK_PRESS: begin
            if (!w_lvl) begin
               w_state_nxt = DB_RELEASED;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = DB_PRESSED;
               o_press     = 1'b1;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         DB_PRESSED: begin
            if (!w_lvl) begin
               w_state_nxt = DB_CHK_RELEASE;
               w_cnt_nxt   = '0;
            end
         end
         DB_CHK_RELEASE: begin
            if (w_lvl) begin
               w_state_nxt = DB_PRESSED;
            end else if (r_cnt == c_CNT_LAST) begin
               w_state_nxt = DB_RELEASED;
            end else begin
               w_cnt_nxt = r_cnt + 16'd1;
            end
         end
         default: w_state_nxt = DB_RELEASED;
      endcase
   end

endmodule
`default_nettype wire

// File: rtl/key_ctrl.sv
`default_nettype none
// ============================================================================
// key_ctrl
// Three debounced keys drive a 4-digit BCD up/down/clear counter with
// registered active-low seven-segment outputs.
// Revision: 1.0
// ============================================================================
module key_ctrl
   import key_ctrl_pkg::*;
#(
   parameter int unsigned DEB_CYCLES = 4,
   parameter logic        KEY_ACT    = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        KEY0,
   input  logic        KEY1,
   input  logic        KEY2,
   output logic [15:0] count_bcd,
   output logic [2:0]  cmd_pulse,
   output logic [6:0]  HEX0,
   output logic [6:0]  HEX1,
   output logic [6:0]  HEX2,
   output logic [6:0]  HEX3
);

   logic [2:0]  w_keys;
   logic [2:0]  w_ev;
   logic [2:0]  w_cmd;
   logic [15:0] w_count_nxt;
   logic [4:0]  w_dig;
   logic        w_carry;
   logic [15:0] r_count;
   logic [2:0]  r_cmd;
   logic [6:0]  r_hex [4];

   // Key index matches the command bit it issues
   assign w_keys = {KEY2, KEY1, KEY0};

   generate
      for (genvar g = 0; g < 3; g++) begin : g_deb
         key_debounce #(
            .DEB_CYCLES (DEB_CYCLES),
            .KEY_ACT    (KEY_ACT)
         ) u_deb (
            .clk     (clk),
            .rst_n   (rst_n),
            .i_key   (w_keys[g]),
            .o_press (w_ev[g])
         );
      end
   endgenerate

   // Fixed-priority arbitration: clear beats increment beats decrement
   always_comb begin
      w_cmd = '0;
      if (w_ev[CMD_CLR])      w_cmd[CMD_CLR] = 1'b1;
      else if (w_ev[CMD_INC]) w_cmd[CMD_INC] = 1'b1;
      else if (w_ev[CMD_DEC]) w_cmd[CMD_DEC] = 1'b1;
   end

   // Per-digit BCD ripple; carry/borrow out of the top digit is dropped (wrap)
   always_comb begin
      w_count_nxt = r_count;
      w_carry     = 1'b1;
      w_dig       = '0;
      for (int i = 0; i < 4; i++) begin
         if (w_cmd[CMD_CLR])      w_dig = 5'd0;
         else if (w_cmd[CMD_INC]) w_dig = bcd_inc_digit(r_count[4*i +: 4], w_carry);
         else if (w_cmd[CMD_DEC]) w_dig = bcd_dec_digit(r_count[4*i +: 4], w_carry);
         else                     w_dig = {1'b0, r_count[4*i +: 4]};
         w_count_nxt[4*i +: 4] = w_dig[3:0];
         w_carry               = w_dig[4];
      end
   end

   // Counter, command strobe and display registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_count <= '0;
         r_cmd   <= '0;
         for (int i = 0; i < 4; i++) r_hex[i] <= 7'h40;
      end else begin
         r_count <= w_count_nxt;
         r_cmd   <= w_cmd;
         for (int i = 0; i < 4; i++) r_hex[i] <= seg7(r_count[4*i +: 4]);
      end
   end

   assign count_bcd = r_count;
   assign cmd_pulse = r_cmd;
   assign HEX0      = r_hex[0];
   assign HEX1      = r_hex[1];
   assign HEX2      = r_hex[2];
   assign HEX3      = r_hex[3];

endmodule
`default_nettype wire
